// File: rtl/race_ctrl.sv
// Reaction-race controller: countdown lamps, per-player throttle integration on a
// millisecond game tick, false-start detection, finish flags and winner latching.
module race_ctrl #(
  parameter int unsigned PLAYERS   = 2,
  parameter int unsigned POS_W     = 11,
  parameter int unsigned TRACK_LEN = 1024,
  parameter int unsigned TICK_DIV  = 65000,
  parameter int unsigned LIGHTS    = 3,
  parameter int unsigned LIGHT_MS  = 1000,
  parameter int unsigned ACCEL     = 1,
  parameter int unsigned MAX_SPEED = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PLAYERS-1:0]       gas,
  output logic [1:0]               state,
  output logic [LIGHTS-1:0]        lights,
  output logic                     go,
  output logic [PLAYERS*POS_W-1:0] position,
  output logic [PLAYERS-1:0]       finished,
  output logic [PLAYERS-1:0]       false_start,
  output logic [2:0]               winner,
  output logic                     winner_valid
);

  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MS_W   = (LIGHT_MS > 1) ? $clog2(LIGHT_MS) : 1;
  localparam int unsigned STEP_W = $clog2(LIGHTS + 1);
  // One spare bit so position + speed cannot wrap before the clamp.
  localparam int unsigned SUM_W  = POS_W + 1;

  localparam logic [PRE_W-1:0]  PreMax   = PRE_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   MsMax    = MS_W'(LIGHT_MS - 1);
  localparam logic [STEP_W-1:0] StepLast = STEP_W'(LIGHTS);
  localparam logic [SUM_W-1:0]  SpeedMax = SUM_W'(MAX_SPEED);
  localparam logic [SUM_W-1:0]  Accel    = SUM_W'(ACCEL);
  localparam logic [SUM_W-1:0]  TrackEnd = SUM_W'(TRACK_LEN);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StCountdown = 2'd1,
    StRace      = 2'd2,
    StDone      = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [PRE_W-1:0]         presc_q, presc_d;
  logic [MS_W-1:0]          ms_q, ms_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic [LIGHTS-1:0]        lights_q, lights_d;
  logic                     go_q, go_d;
  logic [PLAYERS*POS_W-1:0] pos_q, pos_d;
  logic [PLAYERS*POS_W-1:0] spd_q, spd_d;
  logic [PLAYERS-1:0]       fin_q, fin_d;
  logic [PLAYERS-1:0]       fs_q, fs_d;
  logic [2:0]               win_q, win_d;
  logic                     wv_q, wv_d;

  logic                     tick;
  logic                     step_end;
  logic                     cd_done;
  logic                     race_over;
  logic                     restart;
  logic [PLAYERS-1:0]       new_fin;
  logic [SUM_W-1:0]         spd_cur, spd_nxt, pos_sum;

  assign tick     = (presc_q == PreMax);
  // Last tick of the current lamp interval.
  assign step_end = tick && (ms_q == MsMax);
  // Interval after the final lamp has elapsed: green light.
  assign cd_done  = step_end && (step_q == StepLast);
  // Every player either false-started or has crossed the line; vacuous with no racers.
  assign race_over = &(fs_q | fin_d);
  assign restart   = ((state_q == StIdle) || (state_q == StDone)) && start;
  assign new_fin   = fin_d & ~fin_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start)     state_d = StCountdown;
      StCountdown: if (cd_done)   state_d = StRace;
      StRace:      if (race_over) state_d = StDone;
      StDone:      if (start)     state_d = StCountdown;
      default:                    state_d = StIdle;
    endcase
  end

  // Next values of the prescaler, countdown sequencer and race datapath.
  always_comb begin
    presc_d  = presc_q + 1'b1;
    ms_d     = ms_q;
    step_d   = step_q;
    lights_d = lights_q;
    go_d     = go_q;
    pos_d    = pos_q;
    spd_d    = spd_q;
    fin_d    = fin_q;
    fs_d     = fs_q;
    win_d    = win_q;
    wv_d     = wv_q;
    spd_cur  = '0;
    spd_nxt  = '0;
    pos_sum  = '0;

    // Tick phase restarts whenever the FSM enters a new state.
    if ((state_d != state_q) || tick) begin
      presc_d = '0;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (restart) begin
          ms_d     = '0;
          step_d   = '0;
          lights_d = '0;
          go_d     = 1'b0;
          pos_d    = '0;
          spd_d    = '0;
          fin_d    = '0;
          fs_d     = '0;
          win_d    = '0;
          wv_d     = 1'b0;
        end
      end

      StCountdown: begin
        fs_d = fs_q | gas;
        if (tick) begin
          if (step_end) begin
            ms_d = '0;
            if (step_q == StepLast) begin
              go_d = 1'b1;
            end else begin
              step_d      = step_q + 1'b1;
              lights_d    = lights_q << 1;
              lights_d[0] = 1'b1;
            end
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end

      StRace: begin
        if (tick) begin
          for (int i = 0; i < int'(PLAYERS); i++) begin
            if (!fs_q[i] && !fin_q[i]) begin
              spd_cur = {1'b0, spd_q[i*POS_W +: POS_W]};
              if (gas[i]) begin
                spd_nxt = ((spd_cur + Accel) > SpeedMax) ? SpeedMax : (spd_cur + Accel);
              end else begin
                spd_nxt = (spd_cur < Accel) ? '0 : (spd_cur - Accel);
              end
              pos_sum = {1'b0, pos_q[i*POS_W +: POS_W]} + spd_nxt;
              if (pos_sum >= TrackEnd) begin
                pos_sum  = TrackEnd;
                fin_d[i] = 1'b1;
              end
              spd_d[i*POS_W +: POS_W] = spd_nxt[POS_W-1:0];
              pos_d[i*POS_W +: POS_W] = pos_sum[POS_W-1:0];
            end
          end
          // First finishing tick decides; scanning downward leaves the lowest index.
          if (!wv_q && (|new_fin)) begin
            wv_d = 1'b1;
            for (int i = int'(PLAYERS) - 1; i >= 0; i--) begin
              if (new_fin[i]) win_d = 3'(i);
            end
          end
        end
      end

      default: ;
    endcase
  end

  // Datapath registers; all outputs come straight from here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      ms_q     <= '0;
      step_q   <= '0;
      lights_q <= '0;
      go_q     <= 1'b0;
      pos_q    <= '0;
      spd_q    <= '0;
      fin_q    <= '0;
      fs_q     <= '0;
      win_q    <= '0;
      wv_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      step_q   <= step_d;
      lights_q <= lights_d;
      go_q     <= go_d;
      pos_q    <= pos_d;
      spd_q    <= spd_d;
      fin_q    <= fin_d;
      fs_q     <= fs_d;
      win_q    <= win_d;
      wv_q     <= wv_d;
    end
  end

  assign state        = state_q;
  assign lights       = lights_q;
  assign go           = go_q;
  assign position     = pos_q;
  assign finished     = fin_q;
  assign false_start  = fs_q;
  assign winner       = win_q;
  assign winner_valid = wv_q;

endmodule

// File: tb/tb_race_ctrl.sv
// Self-checking bench for race_ctrl: directed race scenarios plus randomized play,
// every cycle compared against a behavioural model of the race rules.
module tb_race_ctrl;

  localparam int P     = 2;
  localparam int PW    = 11;
  localparam int LEN   = 20;
  localparam int TDIV  = 4;
  localparam int NL    = 3;
  localparam int LMS   = 2;
  localparam int ACC   = 1;
  localparam int VMAX  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [P-1:0]    gas = '0;
  logic [1:0]      state;
  logic [NL-1:0]   lights;
  logic            go;
  logic [P*PW-1:0] position;
  logic [P-1:0]    finished;
  logic [P-1:0]    false_start;
  logic [2:0]      winner;
  logic            winner_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  int m_state, m_cyc, m_ticks, m_lamps, m_win;
  int m_pos[P];
  int m_spd[P];
  bit m_fin[P];
  bit m_fs[P];
  bit m_wv, m_go;

  race_ctrl #(
    .PLAYERS(P), .POS_W(PW), .TRACK_LEN(LEN), .TICK_DIV(TDIV), .LIGHTS(NL),
    .LIGHT_MS(LMS), .ACCEL(ACC), .MAX_SPEED(VMAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .gas(gas), .state(state), .lights(lights),
    .go(go), .position(position), .finished(finished), .false_start(false_start),
    .winner(winner), .winner_valid(winner_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_lamps = 0; m_go = 0; m_wv = 0; m_win = 0; m_ticks = 0;
    for (int i = 0; i < P; i++) begin
      m_pos[i] = 0; m_spd[i] = 0; m_fin[i] = 0; m_fs[i] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    m_state = 0;
    m_cyc   = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit st, input logic [P-1:0] g);
    bit tick;
    bit all_done;
    int nxt;
    int first;
    tick = ((m_cyc % TDIV) == TDIV - 1);
    nxt  = m_state;
    case (m_state)
      0, 3: if (st) begin model_clear(); nxt = 1; end
      1: begin
        for (int i = 0; i < P; i++) if (g[i]) m_fs[i] = 1;
        if (tick) begin
          m_ticks++;
          m_lamps = (m_ticks / LMS > NL) ? NL : m_ticks / LMS;
          if (m_ticks == (NL + 1) * LMS) begin m_go = 1; nxt = 2; end
        end
      end
      2: begin
        if (tick) begin
          first = -1;
          for (int i = 0; i < P; i++) begin
            if (!m_fs[i] && !m_fin[i]) begin
              if (g[i]) m_spd[i] = (m_spd[i] + ACC > VMAX) ? VMAX : m_spd[i] + ACC;
              else      m_spd[i] = (m_spd[i] - ACC < 0) ? 0 : m_spd[i] - ACC;
              m_pos[i] += m_spd[i];
              if (m_pos[i] >= LEN) begin
                m_pos[i] = LEN;
                m_fin[i] = 1;
                if (first < 0) first = i;
              end
            end
          end
          if (first >= 0 && !m_wv) begin m_wv = 1; m_win = first; end
        end
        all_done = 1;
        for (int i = 0; i < P; i++) if (!(m_fs[i] || m_fin[i])) all_done = 0;
        if (all_done) nxt = 3;
      end
      default: ;
    endcase
    if (nxt != m_state) begin m_cyc = 0; m_ticks = 0; end
    else m_cyc++;
    m_state = nxt;
  endtask

  task automatic compare_all(input string ph);
    logic [P-1:0] fin_v, fs_v;
    for (int i = 0; i < P; i++) begin fin_v[i] = m_fin[i]; fs_v[i] = m_fs[i]; end
    check_eq({ph, ":state"}, 32'(state), 32'(m_state));
    check_eq({ph, ":lights"}, 32'(lights), 32'((1 << m_lamps) - 1));
    check_eq({ph, ":go"}, 32'(go), 32'(m_go));
    check_eq({ph, ":pos0"}, 32'(position[PW-1:0]), 32'(m_pos[0]));
    check_eq({ph, ":pos1"}, 32'(position[2*PW-1:PW]), 32'(m_pos[1]));
    check_eq({ph, ":finished"}, 32'(finished), 32'(fin_v));
    check_eq({ph, ":false_start"}, 32'(false_start), 32'(fs_v));
    check_eq({ph, ":winner_valid"}, 32'(winner_valid), 32'(m_wv));
    check_eq({ph, ":winner"}, 32'(winner), 32'(m_win));
  endtask

  task automatic cycle(input bit st, input logic [P-1:0] g);
    @(negedge clk);
    start = st;
    gas   = g;
    model_step(st, g);
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    gas   = '0;
    model_reset();
    #1;
    compare_all("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Start pulse plus full countdown; optional gas pulse at countdown cycle pulse_at.
  task automatic run_countdown(input string tag, input logic [P-1:0] pulse, input int pulse_at);
    cycle(1'b1, '0);
    for (int k = 1; k <= 32; k++) begin
      cycle(1'b0, (k == pulse_at) ? pulse : '0);
      if (k == 8)  check_eq({tag, ":lamp1"}, 32'(lights), 32'd1);
      if (k == 16) check_eq({tag, ":lamp2"}, 32'(lights), 32'd3);
      if (k == 24) check_eq({tag, ":lamp3"}, 32'(lights), 32'd7);
      if (k == 31) check_eq({tag, ":no_go_yet"}, 32'(go), 32'd0);
    end
    check_eq({tag, ":go"}, 32'(go), 32'd1);
    check_eq({tag, ":race"}, 32'(state), 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_p0[7];
    bit st;
    logic [P-1:0] g;
    exp_p0 = '{1, 3, 6, 10, 14, 18, 20};

    do_reset();
    check_eq("reset:state", 32'(state), 32'd0);
    check_eq("reset:position", 32'(position), 32'd0);

    // Player 0 races alone; player 1 idles and never finishes.
    run_countdown("cdA", '0, 0);
    for (int t = 0; t < 7; t++) begin
      repeat (TDIV) cycle(1'b0, 2'b01);
      check_eq($sformatf("A:pos0_tick%0d", t + 1), 32'(position[PW-1:0]), 32'(exp_p0[t]));
    end
    check_eq("A:finished", 32'(finished), 32'd1);
    check_eq("A:winner_valid", 32'(winner_valid), 32'd1);
    check_eq("A:winner", 32'(winner), 32'd0);
    check_eq("A:still_race", 32'(state), 32'd2);
    cycle(1'b1, 2'b01);
    check_eq("A:start_ignored", 32'(state), 32'd2);

    // Reset mid-race, then a fresh countdown and a tied finish.
    do_reset();
    check_eq("R:idle", 32'(state), 32'd0);
    check_eq("R:finished", 32'(finished), 32'd0);
    repeat (3) cycle(1'b0, 2'b11);
    check_eq("R:gas_ignored", 32'(state), 32'd0);
    run_countdown("cdB", '0, 0);
    repeat (7 * TDIV) cycle(1'b0, 2'b11);
    check_eq("B:finished", 32'(finished), 32'd3);
    check_eq("B:winner", 32'(winner), 32'd0);
    check_eq("B:done", 32'(state), 32'd3);

    // Restart from DONE; player 1 jumps the lights.
    run_countdown("cdC", 2'b10, 5);
    check_eq("C:false_start", 32'(false_start), 32'd2);
    repeat (7 * TDIV) cycle(1'b0, 2'b11);
    check_eq("C:pos1", 32'(position[2*PW-1:PW]), 32'd0);
    check_eq("C:done", 32'(state), 32'd3);
    check_eq("C:winner", 32'(winner), 32'd0);

    // Both jump the lights: DONE one cycle after go, no winner.
    run_countdown("cdD", 2'b11, 10);
    check_eq("D:false_start", 32'(false_start), 32'd3);
    cycle(1'b0, '0);
    check_eq("D:done", 32'(state), 32'd3);
    check_eq("D:winner_valid", 32'(winner_valid), 32'd0);

    // Randomized play.
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        st = ($urandom_range(0, 39) == 0);
        for (int i = 0; i < P; i++) begin
          if (m_state == 1) g[i] = ($urandom_range(0, 199) == 0);
          else              g[i] = ($urandom_range(0, 99) < 75);
        end
        cycle(st, g);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
